// File: rtl/multicycle_control.sv
// Multi-cycle MIPS-style control unit.
// A state machine steps each instruction through fetch, decode and its
// execute/memory/writeback states. Datapath controls are decoded from the
// current state. A wait counter sends any memory handshake that stalls too
// long into TRAP. A free-running counter tallies retired instructions.
module multicycle_control #(
  parameter int WAIT_LIMIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ir_write,
  output logic        iord,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  pc_source,
  output logic        instr_done,
  output logic [31:0] instr_count,
  output logic        trap,
  output logic [3:0]  state
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEM_ADDR = 4'd2;
  localparam logic [3:0] S_MEM_RD   = 4'd3;
  localparam logic [3:0] S_MEM_WB   = 4'd4;
  localparam logic [3:0] S_MEM_WR   = 4'd5;
  localparam logic [3:0] S_R_EX     = 4'd6;
  localparam logic [3:0] S_R_WB     = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_JUMP     = 4'd9;
  localparam logic [3:0] S_I_EX     = 4'd10;
  localparam logic [3:0] S_I_WB     = 4'd11;
  localparam logic [3:0] S_TRAP     = 4'd15;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // The counter has to hold the value WAIT_LIMIT itself, hence the +1.
  localparam int WAIT_W = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(WAIT_LIMIT);

  logic [3:0]        state_q;
  logic [3:0]        state_d;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_wait_state;
  logic              wait_expired;

  assign state          = state_q;
  assign mem_wait_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                          (state_q == S_MEM_WR);
  // The limit cycle is the one in which the counter already equals WAIT_LIMIT.
  // A ready in that same cycle still completes the handshake normally.
  assign wait_expired   = (wait_cnt == WAIT_MAX) && !mem_ready;

  // Next-state selection; mem_ready only matters in the three handshake states.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready)         state_d = S_DECODE;
        else if (wait_expired) state_d = S_TRAP;
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:   state_d = S_MEM_ADDR;
          OP_RTYPE:       state_d = S_R_EX;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:           state_d = S_JUMP;
          OP_ADDI:        state_d = S_I_EX;
          default:        state_d = S_TRAP;
        endcase
      end
      S_MEM_ADDR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (mem_ready)         state_d = S_MEM_WB;
        else if (wait_expired) state_d = S_TRAP;
      end
      S_MEM_WB: state_d = S_FETCH;
      S_MEM_WR: begin
        if (mem_ready)         state_d = S_FETCH;
        else if (wait_expired) state_d = S_TRAP;
      end
      S_R_EX:   state_d = S_R_WB;
      S_R_WB:   state_d = S_FETCH;
      S_I_EX:   state_d = S_I_WB;
      S_I_WB:   state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_TRAP;
    endcase
  end

  // State register; reset wins from any state, including TRAP.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Wait counter restarts on every state change, so entering a handshake
  // state always begins at zero, and it counts stalled handshake cycles.
  always_ff @(posedge clk) begin
    if (rst)                             wait_cnt <= '0;
    else if (state_d != state_q)         wait_cnt <= '0;
    else if (mem_wait_state && !mem_ready) wait_cnt <= wait_cnt + WAIT_W'(1);
  end

  // Control decode; everything is held low while reset is asserted.
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_source  = 2'b00;
    instr_done = 1'b0;
    trap       = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: alu_src_b = 2'b11;
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        S_MEM_WR: begin
          mem_write  = 1'b1;
          iord       = 1'b1;
          instr_done = mem_ready;
        end
        S_R_EX: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        S_R_WB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
        end
        S_I_EX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_op    = 2'b11;
        end
        S_I_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a  = 1'b1;
          alu_op     = 2'b01;
          pc_source  = 2'b01;
          pc_write   = (opcode == OP_BNE) ? !alu_zero : alu_zero;
          instr_done = 1'b1;
        end
        S_JUMP: begin
          pc_source  = 2'b10;
          pc_write   = 1'b1;
          instr_done = 1'b1;
        end
        S_TRAP:  trap = 1'b1;
        default: trap = 1'b0;
      endcase
    end
  end

  // Retired-instruction counter; written every cycle and wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) instr_count <= '0;
    else     instr_count <= instr_count + {31'b0, instr_done};
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: a vector table for whole
// instructions plus hand-written sequences for waits, traps and resets.
module tb_multicycle_control;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_ADD = 6'b001000;
  localparam logic [5:0] OP_BAD = 6'b111111;

  typedef struct {
    logic        rst_v;
    logic [5:0]  op;
    logic        az;
    logic        mr;
    logic [3:0]  st;
    logic [16:0] ctrl;
    logic [31:0] cnt;
  } vec_t;

  typedef struct {
    logic [3:0]  st;
    logic [16:0] ctrl;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode;
  logic        alu_zero;
  logic        mem_ready;
  logic        pc_write, ir_write, iord, mem_read, mem_write;
  logic        reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic        instr_done, trap;
  logic [31:0] instr_count;
  logic [3:0]  state;
  logic [16:0] act_ctrl;

  int   total = 0;
  int   bad   = 0;
  vec_t vecs[$];
  exp_t sb[$];

  logic [16:0] c_rst, c_fetch_wait, c_fetch_rdy, c_decode, c_mem_addr, c_mem_rd;
  logic [16:0] c_mem_wb, c_wr_wait, c_wr_done, c_r_ex, c_r_wb, c_i_ex, c_i_wb;
  logic [16:0] c_br_take, c_br_not, c_jump, c_trap;

  multicycle_control #(.WAIT_LIMIT(16)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .instr_done(instr_done),
    .instr_count(instr_count), .trap(trap), .state(state)
  );

  assign act_ctrl = {pc_write, ir_write, iord, mem_read, mem_write, reg_write,
                     reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                     pc_source, instr_done, trap};

  // Free-running clock.
  always #5 clk = ~clk;

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, required finish before it");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [16:0] ctrl(input logic pcw, input logic irw,
      input logic io, input logic mr, input logic mw, input logic rw,
      input logic rd, input logic m2r, input logic asa, input logic [1:0] asb,
      input logic [1:0] aop, input logic [1:0] ps, input logic done,
      input logic trp);
    return {pcw, irw, io, mr, mw, rw, rd, m2r, asa, asb, aop, ps, done, trp};
  endfunction

  function automatic vec_t mkv(input logic r, input logic [5:0] op,
      input logic az, input logic mr, input logic [3:0] st,
      input logic [16:0] c, input logic [31:0] n);
    vec_t v;
    v.rst_v = r; v.op = op; v.az = az; v.mr = mr;
    v.st = st; v.ctrl = c; v.cnt = n;
    return v;
  endfunction

  // Drive one cycle's inputs at the falling edge and queue what the DUT
  // must show during that cycle.
  task automatic applyStimulus(input logic r, input logic [5:0] op,
      input logic az, input logic mr, input exp_t e);
    @(negedge clk);
    rst       = r;
    opcode    = op;
    alu_zero  = az;
    mem_ready = mr;
    sb.push_back(e);
    #1;
  endtask

  // Pop the oldest expectation and compare it with the DUT outputs.
  task automatic checkOutput(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("[TB] FAIL %s scoreboard empty: got no expectation, required one", tag);
      return;
    end
    e = sb.pop_front();
    total++;
    if (state !== e.st) begin
      bad++;
      $display("[TB] FAIL %s state: got %0d required %0d", tag, state, e.st);
    end
    total++;
    if (act_ctrl !== e.ctrl) begin
      bad++;
      $display("[TB] FAIL %s ctrl: got %b required %b", tag, act_ctrl, e.ctrl);
    end
    total++;
    if (instr_count !== e.cnt) begin
      bad++;
      $display("[TB] FAIL %s instr_count: got %h required %h", tag, instr_count, e.cnt);
    end
  endtask

  task automatic step(input logic r, input logic [5:0] op, input logic az,
      input logic mr, input logic [3:0] st, input logic [16:0] c,
      input logic [31:0] n, input string tag);
    exp_t e;
    e.st = st; e.ctrl = c; e.cnt = n;
    applyStimulus(r, op, az, mr, e);
    checkOutput(tag);
  endtask

  // Hold reset across at least one rising edge before the next check.
  task automatic hold_reset();
    @(negedge clk);
    rst       = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; opcode = OP_LW; alu_zero = 1'b0; mem_ready = 1'b0;

    c_rst        = '0;
    c_fetch_wait = ctrl(0,0,0,1,0,0,0,0,0,2'b01,2'b00,2'b00,0,0);
    c_fetch_rdy  = ctrl(1,1,0,1,0,0,0,0,0,2'b01,2'b00,2'b00,0,0);
    c_decode     = ctrl(0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0);
    c_mem_addr   = ctrl(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0);
    c_mem_rd     = ctrl(0,0,1,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0);
    c_mem_wb     = ctrl(0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,1,0);
    c_wr_wait    = ctrl(0,0,1,0,1,0,0,0,0,2'b00,2'b00,2'b00,0,0);
    c_wr_done    = ctrl(0,0,1,0,1,0,0,0,0,2'b00,2'b00,2'b00,1,0);
    c_r_ex       = ctrl(0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,0);
    c_r_wb       = ctrl(0,0,0,0,0,1,1,0,0,2'b00,2'b00,2'b00,1,0);
    c_i_ex       = ctrl(0,0,0,0,0,0,0,0,1,2'b10,2'b11,2'b00,0,0);
    c_i_wb       = ctrl(0,0,0,0,0,1,0,0,0,2'b00,2'b00,2'b00,1,0);
    c_br_take    = ctrl(1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,1,0);
    c_br_not     = ctrl(0,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,1,0);
    c_jump       = ctrl(1,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1,0);
    c_trap       = ctrl(0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,1);

    // lw, R-type, addi, beq/bne both ways, sw with 3 stalls, j, bad opcode.
    vecs.push_back(mkv(1, OP_LW,  0, 1,  0, c_rst,       0));
    vecs.push_back(mkv(0, OP_LW,  0, 1,  0, c_fetch_rdy, 0));
    vecs.push_back(mkv(0, OP_LW,  0, 1,  1, c_decode,    0));
    vecs.push_back(mkv(0, OP_LW,  0, 1,  2, c_mem_addr,  0));
    vecs.push_back(mkv(0, OP_LW,  0, 1,  3, c_mem_rd,    0));
    vecs.push_back(mkv(0, OP_LW,  0, 1,  4, c_mem_wb,    0));
    vecs.push_back(mkv(0, OP_R,   0, 1,  0, c_fetch_rdy, 1));
    vecs.push_back(mkv(0, OP_R,   0, 1,  1, c_decode,    1));
    vecs.push_back(mkv(0, OP_R,   0, 1,  6, c_r_ex,      1));
    vecs.push_back(mkv(0, OP_R,   0, 1,  7, c_r_wb,      1));
    vecs.push_back(mkv(0, OP_ADD, 0, 1,  0, c_fetch_rdy, 2));
    vecs.push_back(mkv(0, OP_ADD, 0, 1,  1, c_decode,    2));
    vecs.push_back(mkv(0, OP_ADD, 0, 1, 10, c_i_ex,      2));
    vecs.push_back(mkv(0, OP_ADD, 0, 1, 11, c_i_wb,      2));
    vecs.push_back(mkv(0, OP_BEQ, 1, 1,  0, c_fetch_rdy, 3));
    vecs.push_back(mkv(0, OP_BEQ, 1, 1,  1, c_decode,    3));
    vecs.push_back(mkv(0, OP_BEQ, 1, 1,  8, c_br_take,   3));
    vecs.push_back(mkv(0, OP_BEQ, 0, 1,  0, c_fetch_rdy, 4));
    vecs.push_back(mkv(0, OP_BEQ, 0, 1,  1, c_decode,    4));
    vecs.push_back(mkv(0, OP_BEQ, 0, 1,  8, c_br_not,    4));
    vecs.push_back(mkv(0, OP_BNE, 0, 1,  0, c_fetch_rdy, 5));
    vecs.push_back(mkv(0, OP_BNE, 0, 1,  1, c_decode,    5));
    vecs.push_back(mkv(0, OP_BNE, 0, 1,  8, c_br_take,   5));
    vecs.push_back(mkv(0, OP_BNE, 1, 1,  0, c_fetch_rdy, 6));
    vecs.push_back(mkv(0, OP_BNE, 1, 1,  1, c_decode,    6));
    vecs.push_back(mkv(0, OP_BNE, 1, 1,  8, c_br_not,    6));
    vecs.push_back(mkv(0, OP_SW,  0, 1,  0, c_fetch_rdy, 7));
    vecs.push_back(mkv(0, OP_SW,  0, 1,  1, c_decode,    7));
    vecs.push_back(mkv(0, OP_SW,  0, 1,  2, c_mem_addr,  7));
    vecs.push_back(mkv(0, OP_SW,  0, 0,  5, c_wr_wait,   7));
    vecs.push_back(mkv(0, OP_SW,  0, 0,  5, c_wr_wait,   7));
    vecs.push_back(mkv(0, OP_SW,  0, 0,  5, c_wr_wait,   7));
    vecs.push_back(mkv(0, OP_SW,  0, 1,  5, c_wr_done,   7));
    vecs.push_back(mkv(0, OP_J,   0, 1,  0, c_fetch_rdy, 8));
    vecs.push_back(mkv(0, OP_J,   0, 0,  1, c_decode,    8));
    vecs.push_back(mkv(0, OP_J,   0, 1,  9, c_jump,      8));
    vecs.push_back(mkv(0, OP_BAD, 0, 1,  0, c_fetch_rdy, 9));
    vecs.push_back(mkv(0, OP_BAD, 0, 1,  1, c_decode,    9));
    vecs.push_back(mkv(0, OP_BAD, 0, 1, 15, c_trap,      9));
    vecs.push_back(mkv(0, OP_BAD, 0, 0, 15, c_trap,      9));
    vecs.push_back(mkv(1, OP_BAD, 0, 0, 15, c_rst,       9));
    vecs.push_back(mkv(0, OP_LW,  0, 0,  0, c_fetch_wait, 0));

    hold_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      exp_t e;
      e.st = vecs[i].st; e.ctrl = vecs[i].ctrl; e.cnt = vecs[i].cnt;
      applyStimulus(vecs[i].rst_v, vecs[i].op, vecs[i].az, vecs[i].mr, e);
      checkOutput($sformatf("vec%0d", i));
    end

    // Retire one j, then a bad opcode traps and stays there until reset.
    hold_reset();
    step(1, OP_J, 0, 1, 0, c_rst, 0, "trap_rst0");
    step(0, OP_J, 0, 1, 0, c_fetch_rdy, 0, "trap_fetch_j");
    step(0, OP_J, 0, 1, 1, c_decode, 0, "trap_dec_j");
    step(0, OP_J, 0, 1, 9, c_jump, 0, "trap_jump");
    step(0, OP_BAD, 0, 1, 0, c_fetch_rdy, 1, "trap_fetch_bad");
    step(0, OP_BAD, 0, 1, 1, c_decode, 1, "trap_dec_bad");
    for (int k = 0; k < 10; k++)
      step(0, OP_BAD, 0, k[0], 15, c_trap, 1, $sformatf("trap_hold%0d", k));
    step(1, OP_BAD, 0, 1, 15, c_rst, 1, "trap_rst_in");
    step(1, OP_BAD, 0, 1, 0, c_rst, 0, "trap_rst_out");

    // FETCH stalls: 16 waiting cycles, then the limit cycle decides.
    hold_reset();
    step(1, OP_LW, 0, 0, 0, c_rst, 0, "to_rst");
    for (int k = 0; k <= 16; k++)
      step(0, OP_LW, 0, 0, 0, c_fetch_wait, 0, $sformatf("to_wait%0d", k));
    step(0, OP_LW, 0, 0, 15, c_trap, 0, "to_trap");
    hold_reset();
    step(1, OP_LW, 0, 0, 0, c_rst, 0, "ok_rst");
    for (int k = 0; k < 16; k++)
      step(0, OP_LW, 0, 0, 0, c_fetch_wait, 0, $sformatf("ok_wait%0d", k));
    step(0, OP_LW, 0, 1, 0, c_fetch_rdy, 0, "ok_limit_ready");
    step(0, OP_LW, 0, 0, 1, c_decode, 0, "ok_decode");

    // MEM_RD starts its own count after a long FETCH stall.
    hold_reset();
    step(1, OP_LW, 0, 0, 0, c_rst, 0, "clr_rst");
    for (int k = 0; k < 10; k++)
      step(0, OP_LW, 0, 0, 0, c_fetch_wait, 0, $sformatf("clr_fwait%0d", k));
    step(0, OP_LW, 0, 1, 0, c_fetch_rdy, 0, "clr_fetch");
    step(0, OP_LW, 0, 0, 1, c_decode, 0, "clr_decode");
    step(0, OP_LW, 0, 0, 2, c_mem_addr, 0, "clr_addr");
    for (int k = 0; k < 16; k++)
      step(0, OP_LW, 0, 0, 3, c_mem_rd, 0, $sformatf("clr_rwait%0d", k));
    step(0, OP_LW, 0, 1, 3, c_mem_rd, 0, "clr_rd_limit");
    step(0, OP_LW, 0, 0, 4, c_mem_wb, 0, "clr_wb");
    step(0, OP_LW, 0, 0, 0, c_fetch_wait, 1, "clr_fetch2");

    // Reset in the middle of a MEM_RD stall.
    hold_reset();
    step(1, OP_LW, 0, 1, 0, c_rst, 0, "mr_rst");
    step(0, OP_LW, 0, 1, 0, c_fetch_rdy, 0, "mr_fetch");
    step(0, OP_LW, 0, 1, 1, c_decode, 0, "mr_decode");
    step(0, OP_LW, 0, 1, 2, c_mem_addr, 0, "mr_addr");
    step(0, OP_LW, 0, 0, 3, c_mem_rd, 0, "mr_wait0");
    step(0, OP_LW, 0, 0, 3, c_mem_rd, 0, "mr_wait1");
    step(1, OP_LW, 0, 0, 3, c_rst, 0, "mr_rst_in");
    step(1, OP_LW, 0, 0, 0, c_rst, 0, "mr_rst_fetch");
    step(0, OP_LW, 0, 0, 0, c_fetch_wait, 0, "mr_release");

    // Counter wraps from all-ones to zero on a retired j.
    hold_reset();
    step(1, OP_J, 0, 0, 0, c_rst, 0, "wrap_rst");
    step(0, OP_J, 0, 0, 0, c_fetch_wait, 0, "wrap_wait");
    force dut.instr_count = 32'hFFFF_FFFF;
    step(0, OP_J, 0, 0, 0, c_fetch_wait, 32'hFFFF_FFFF, "wrap_forced");
    release dut.instr_count;
    step(0, OP_J, 0, 1, 0, c_fetch_rdy, 32'hFFFF_FFFF, "wrap_fetch");
    step(0, OP_J, 0, 0, 1, c_decode, 32'hFFFF_FFFF, "wrap_decode");
    step(0, OP_J, 0, 0, 9, c_jump, 32'hFFFF_FFFF, "wrap_jump");
    step(0, OP_J, 0, 0, 0, c_fetch_wait, 32'h0000_0000, "wrap_zero");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter WAIT_LIMIT, default 16: maximum cycles any memory state waits for mem_ready before trapping.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 opcode  input  6  instruction bits [31:26] from the instruction register.
REQ-005 alu_zero  input  1  ALU zero flag.
REQ-006 mem_ready  input  1  memory handshake; current read/write completes in the cycle it is high.
REQ-007 pc_write  output  1  PC load enable.
REQ-008 ir_write  output  1  instruction register load enable.
REQ-009 iord  output  1  memory address select: 0 = PC, 1 = ALU result.
REQ-010 mem_read, mem_write  output  1 each  memory request strobes.
REQ-011 reg_write, reg_dst, mem_to_reg  output  1 each  register-file write enable, destination select (1 = rd), write-data select (1 = memory).
REQ-012 alu_src_a  output  1  0 = PC, 1 = rs; alu_src_b  output  2  00 = rt, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
REQ-013 alu_op  output  2  00 = add, 01 = subtract, 10 = funct-decoded, 11 = add-immediate.
REQ-014 pc_source  output  2  00 = ALU result, 01 = ALUOut (branch target), 10 = jump target.
REQ-015 instr_done  output  1  one-cycle pulse when an instruction retires.
REQ-016 instr_count  output  32  retired-instruction counter.
REQ-017 trap  output  1  high while in TRAP.
REQ-018 state  output  4  current state encoding, for debug.

Function
REQ-019 States and encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EX=6, R_WB=7, BRANCH=8, JUMP=9, I_EX=10, I_WB=11, TRAP=15.
REQ-020 Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, bne 000101, j 000010, addi 001000.
REQ-021 Outputs are decoded from state; the exceptions are pc_write, ir_write and instr_done, which also depend on the inputs as specified below.
REQ-022 FETCH drives mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
REQ-023 FETCH asserts ir_write=1 and pc_write=1 only in the cycle mem_ready=1, then goes to DECODE; otherwise it stays in FETCH.
REQ-024 DECODE drives alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut).
REQ-025 DECODE next state: lw/sw -> MEM_ADDR; R-type -> R_EX; beq/bne -> BRANCH; j -> JUMP; addi -> I_EX; any other opcode -> TRAP.
REQ-026 MEM_ADDR drives alu_src_a=1, alu_src_b=10, alu_op=00, then goes to MEM_RD for lw or MEM_WR for sw.
REQ-027 MEM_RD drives mem_read=1, iord=1 and goes to MEM_WB on mem_ready.
REQ-028 MEM_WB drives reg_write=1, mem_to_reg=1, reg_dst=0, retires, and goes to FETCH.
REQ-029 MEM_WR drives mem_write=1, iord=1; on mem_ready it retires and goes to FETCH.
REQ-030 R_EX drives alu_src_a=1, alu_src_b=00, alu_op=10 and goes to R_WB.
REQ-031 R_WB drives reg_write=1, reg_dst=1, mem_to_reg=0, retires, and goes to FETCH.
REQ-032 I_EX drives alu_src_a=1, alu_src_b=10, alu_op=11 and goes to I_WB.
REQ-033 I_WB drives reg_write=1, reg_dst=0, mem_to_reg=0, retires, and goes to FETCH.
REQ-034 BRANCH drives alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01.
REQ-035 In BRANCH, pc_write = alu_zero for beq and !alu_zero for bne; BRANCH always retires and goes to FETCH.
REQ-036 JUMP drives pc_source=10, pc_write=1, retires, and goes to FETCH.
REQ-037 Retire means instr_done=1 for that cycle and instr_count increments by 1, wrapping from 0xFFFFFFFF to 0.
REQ-038 A wait counter clears on entry to FETCH, MEM_RD or MEM_WR and increments each cycle that mem_ready=0 in those states.
REQ-039 When the wait counter reaches WAIT_LIMIT with mem_ready still 0, the next state is TRAP.
REQ-040 If mem_ready=1 in the limit cycle, the handshake completes normally and no trap occurs.
REQ-041 mem_ready is ignored in every state other than FETCH, MEM_RD and MEM_WR.
REQ-042 TRAP drives trap=1 with every strobe and write enable at 0, and is left only by rst.
REQ-043 Unused outputs in each state are 0.

Reset
REQ-044 rst=1 at posedge clk sets state=FETCH, instr_count=0 and the wait counter to 0, in any state including mid-handshake and TRAP.
REQ-045 While rst=1, all outputs except state are forced to 0, so no memory request or write escapes during reset.
REQ-046 In the first cycle after rst falls, the block is in FETCH with mem_read=1.

Verification
REQ-047 Reset held, then released; opcode=100011 (lw), mem_ready=1 in every cycle -> states 0,1,2,3,4,0; instr_done pulses once; instr_count=1.
REQ-048 sw with mem_ready low for 3 cycles in MEM_WR -> mem_write held 4 cycles; retire on the 4th; instr_count increments by exactly 1.
REQ-049 beq with alu_zero=1 -> pc_write=1 and pc_source=01 in BRANCH; beq with alu_zero=0 -> pc_write=0; bne with alu_zero=0 -> pc_write=1.
REQ-050 opcode=111111 in DECODE -> TRAP next cycle; trap=1 held for 10 cycles; rst=1 -> state=0, trap=0, instr_count=0.
REQ-051 mem_ready held 0 in FETCH with WAIT_LIMIT=16 -> TRAP; the same stimulus with mem_ready=1 in the limit cycle -> DECODE.
REQ-052 Preload instr_count=0xFFFFFFFF by forcing, then retire one j -> instr_count=0; assert rst in the MEM_RD wait -> state=FETCH next cycle and mem_read=0 during reset.
